// File: rtl/mem_responder.sv
// mem_responder: memory-side end of the control unit's memory handshake.
// Word-organised RAM with programmable wait states, byte/half load extension,
// byte-lane store merge and a one-cycle mem_data_ready completion pulse.
// Optional feature macro: MEM_RESPONDER_FAULT_EN adds the mem_fault output,
// pulsed alongside mem_data_ready for out-of-range or read+write requests.
module mem_responder #(
  parameter int    DEPTH_WORDS = 131072,
  parameter int    WAIT_STATES = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_size,
  input  logic        mem_addr_ready,
  output logic        mem_data_ready,
  output logic [31:0] rdata,
  output logic        mem_bus_en
`ifdef MEM_RESPONDER_FAULT_EN
  ,
  output logic        mem_fault
`else
`endif
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    RECOVER
  } state_t;

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [3:0]  lat_size;
  logic        op_read;
  logic        op_write;

  logic [31:0] ram [DEPTH_WORDS];

  logic          accept;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic [31:0]   ram_word;
  logic [3:0]    lane_en;
  logic [31:0]   lane_data;

  // Sign/zero extension of the selected byte or half; size 0 means full word.
  function automatic logic [31:0] extend_load(input logic [31:0] w,
                                              input logic [1:0]  lo,
                                              input logic [3:0]  sz);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{lo, 3'b000} +: 8];
    h = lo[1] ? w[31:16] : w[15:0];
    r = w;
    if (sz[3])      r = {{24{b[7]}}, b};
    else if (sz[2]) r = {24'h000000, b};
    else if (sz[1]) r = {{16{h[15]}}, h};
    else if (sz[0]) r = {16'h0000, h};
    return r;
  endfunction

  assign accept   = mem_addr_ready && (mem_read || mem_write);
  assign in_range = ({2'b00, lat_addr[31:2]} < 32'(DEPTH_WORDS));
  assign word_idx = lat_addr[AW+1:2];
  assign ram_word = in_range ? ram[word_idx] : 32'h0;

  // Store lane enables and lane-replicated store data; low address bits are truncated per size.
  always_comb begin
    lane_en   = 4'b1111;
    lane_data = lat_wdata;
    if (lat_size[3] || lat_size[2]) begin
      lane_en   = 4'b0001 << lat_addr[1:0];
      lane_data = {4{lat_wdata[7:0]}};
    end else if (lat_size[1] || lat_size[0]) begin
      lane_en   = lat_addr[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{lat_wdata[15:0]}};
    end
  end

  // Handshake FSM: accept, count wait states, pulse completion, then wait for strobe to drop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      wait_cnt       <= 4'd0;
      lat_addr       <= 32'h0;
      lat_wdata      <= 32'h0;
      lat_size       <= 4'h0;
      op_read        <= 1'b0;
      op_write       <= 1'b0;
      mem_data_ready <= 1'b0;
      rdata          <= 32'h0;
      mem_bus_en     <= 1'b0;
    end else begin
      mem_data_ready <= 1'b0;
      rdata          <= 32'h0;
      mem_bus_en     <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
            lat_size  <= mem_size;
            op_read   <= mem_read;
            op_write  <= mem_write && !mem_read;
            wait_cnt  <= 4'd0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (!mem_addr_ready) begin
            state <= IDLE;
          end else if (wait_cnt == 4'(WAIT_STATES)) begin
            state          <= DONE;
            mem_data_ready <= 1'b1;
            mem_bus_en     <= op_read;
            rdata          <= op_read ? extend_load(ram_word, lat_addr[1:0], lat_size) : 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        DONE: begin
          state <= RECOVER;
        end
        RECOVER: begin
          if (!mem_addr_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write port: commits on the DONE cycle only, never touched by reset.
  always_ff @(posedge clk) begin
    if (state == DONE && op_write && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) ram[word_idx][8*i +: 8] <= lane_data[8*i +: 8];
      end
    end
  end

`ifdef MEM_RESPONDER_FAULT_EN
  logic op_both;

  // Fault flag: remembers a read+write request and pulses with completion when the access was bad.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_both   <= 1'b0;
      mem_fault <= 1'b0;
    end else begin
      mem_fault <= 1'b0;
      if (state == IDLE && accept) op_both <= mem_read && mem_write;
      if (state == ACCESS && mem_addr_ready && wait_cnt == 4'(WAIT_STATES))
        mem_fault <= !in_range || op_both;
    end
  end
`else
`endif

endmodule
